apo_delivery_monitor_5: RTL and testbench
=========================================

# apo_delivery_monitor_5

Packet-sink and statistics block for the 5-node circulant NoC. It consumes the per-router delivery strobes (the `out_data` bits driven by each router when a packet addressed to it arrives) and counts deliveries per node and in total. It measures injection-to-first-delivery latency and drives the board's seven-segment displays. It is the receiving counterpart of the switch/key packet composer (`select_data_5`) that injects packets, and sits beside it in the 5-node toplevel.

## Interface
Parameters:
- `N_NODES`, 5, number of routers monitored.
- `CNT_W`, 4, width of each per-node delivery counter.
- `TOT_W`, 8, width of the total delivery counter.
- `LAT_W`, 8, width of the latency counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `delivered`  in  N_NODES  level strobes from routers; bit i = router i delivered.
- `start`  in  1  one-cycle pulse from the injector when a packet is launched.
- `sw_clear`  in  1  level; while high, clears statistics.
- `key_next`  in  1  push-button, active-low, asynchronous to `clk`; selects next node for display.
- `hex_count`  out  7  active-low 7-segment pattern of the selected node's count (hex digit).
- `hex_router`  out  7  active-low 7-segment pattern of the selected node index.
- `total`  out  TOT_W  total deliveries, saturating.
- `last_router`  out  3  index of the most recent delivering node.
- `last_valid`  out  1  at least one delivery since reset/clear.
- `latency`  out  LAT_W  cycles from `start` to first delivery.
- `lat_valid`  out  1  `latency` holds a completed measurement.
- `lat_timeout`  out  1  measurement ended by saturation, not delivery.

## Operation
- Delivery event: `ev[i] = delivered[i] & ~d_q[i]`, where `d_q` is `delivered` registered each cycle; `d_q` resets to 0.
- Per-node counter i: +1 on `ev[i]`, saturates at 2^CNT_W−1.
- `total`: adds popcount(`ev`) (0..5) per cycle, saturates at 2^TOT_W−1. Width-extend before adding; clamp the result.
- `last_router`: lowest index set in `ev` when `ev` ≠ 0. `last_valid` is set on the same edge.
- Latency FSM, states IDLE, RUN, DONE:
  - IDLE: `start` → RUN, with `lat_cnt`=0.
  - RUN: `lat_cnt` +1 per cycle.
    - Any `ev` bit → DONE; latch `latency`=`lat_cnt`, set `lat_valid`=1, `lat_timeout`=0.
    - `lat_cnt` = 2^LAT_W−1 with no event → DONE; set `latency`=max, `lat_valid`=1, `lat_timeout`=1.
    - `start` in RUN restarts: `lat_cnt`=0, stays in RUN. `start` has priority over `ev` in the same cycle.
  - DONE: holds outputs; `start` → RUN and clears `lat_valid`/`lat_timeout`.
- `sw_clear` high:
  - Counters, `total`, `last_router`, `last_valid`, `latency`, `lat_valid`, `lat_timeout` → 0. FSM → IDLE.
  - Overrides `ev` and `start` in the same cycle. `d_q` keeps tracking, so a level held across clear release is not recounted.
- Display select:
  - `key_next` goes through a two-flop synchronizer, then falling-edge detection.
  - Each press increments `sel`, wrapping 4→0.
  - `hex_router` = seg7(`sel`); `hex_count` = seg7(count[`sel`]).

## Timing
- Reset values: all counters 0; `sel`=0; FSM IDLE; `last_router`=0; `last_valid`=`lat_valid`=`lat_timeout`=0; `latency`=0; `hex_router`=seg7(0)=7'b1000000; `hex_count`=7'b1000000.
- Delivery latency: `delivered[i]` rising, sampled at edge k → counters/`total`/`last_router` updated at edge k (visible after k). `hex_count` is combinational from registers.
- Latency measurement: `start` at edge s, first `ev` at edge e → `latency` = e−s−1 (delivery on the cycle right after start = 0).
- Key: falling `key_next` becomes visible in `sel` 3 edges after the asynchronous fall. No debounce in this block.
- `rst` mid-measurement aborts to IDLE; `rst` wins over everything.

## Structure
- Package `apo_mon_pkg`: `N_NODES`, width constants, FSM state enum (IDLE/RUN/DONE), seg7 active-low constants.
- Sub-module `hex_to_seg7` (4-bit → 7-bit active-low decoder), two instances.

## Test plan
- Reset then single pulse on `delivered[2]` for 3 cycles → count[2]=1, `total`=1, `last_router`=2, `last_valid`=1.
- `delivered`=5'b10101 rising in one cycle → counts 0/2/4 each +1, `total`=3, `last_router`=0.
- 20 separate pulses on node 1 → count[1]=15 (saturated), `total`=20. Press `key_next` once → `hex_router`=seg7(1), `hex_count`=seg7(F)=7'b0001110.
- `start` at edge 10, `delivered[4]` rises at edge 17 → `latency`=6, `lat_valid`=1, `lat_timeout`=0.
- `start` with no delivery for 300 cycles → `latency`=255, `lat_timeout`=1. `sw_clear` asserted in the same cycle as a delivery edge → all stats 0, no count.
- Five presses of `key_next` → `sel` sequence 1,2,3,4,0. Assert `rst` during RUN → IDLE, `lat_valid`=0.

Source files
------------

// File: rtl/apo_mon_pkg.sv
// Shared constants, latency FSM states and active-low seven-segment patterns
// for the 5-node delivery monitor.
package apo_mon_pkg;

    localparam int N_NODES = 5;
    localparam int CNT_W   = 4;
    localparam int TOT_W   = 8;
    localparam int LAT_W   = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } lat_state_e;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0.
    localparam logic [6:0] SEG7_0 = 7'b1000000;
    localparam logic [6:0] SEG7_1 = 7'b1111001;
    localparam logic [6:0] SEG7_2 = 7'b0100100;
    localparam logic [6:0] SEG7_3 = 7'b0110000;
    localparam logic [6:0] SEG7_4 = 7'b0011001;
    localparam logic [6:0] SEG7_5 = 7'b0010010;
    localparam logic [6:0] SEG7_6 = 7'b0000010;
    localparam logic [6:0] SEG7_7 = 7'b1111000;
    localparam logic [6:0] SEG7_8 = 7'b0000000;
    localparam logic [6:0] SEG7_9 = 7'b0010000;
    localparam logic [6:0] SEG7_A = 7'b0001000;
    localparam logic [6:0] SEG7_B = 7'b0000011;
    localparam logic [6:0] SEG7_C = 7'b1000110;
    localparam logic [6:0] SEG7_D = 7'b0100001;
    localparam logic [6:0] SEG7_E = 7'b0000110;
    localparam logic [6:0] SEG7_F = 7'b0001110;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'h0:    seg = SEG7_0;
            4'h1:    seg = SEG7_1;
            4'h2:    seg = SEG7_2;
            4'h3:    seg = SEG7_3;
            4'h4:    seg = SEG7_4;
            4'h5:    seg = SEG7_5;
            4'h6:    seg = SEG7_6;
            4'h7:    seg = SEG7_7;
            4'h8:    seg = SEG7_8;
            4'h9:    seg = SEG7_9;
            4'hA:    seg = SEG7_A;
            4'hB:    seg = SEG7_B;
            4'hC:    seg = SEG7_C;
            4'hD:    seg = SEG7_D;
            4'hE:    seg = SEG7_E;
            default: seg = SEG7_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/apo_delivery_monitor_5_hex_to_seg7.sv
// Hex digit to active-low seven-segment decoder.
module hex_to_seg7
    import apo_mon_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // Pure lookup of the digit pattern
    always_comb begin
        seg = seg7(hex);
    end

endmodule

// File: rtl/apo_delivery_monitor_5.sv
// Delivery statistics sink for the 5-node circulant NoC: per-node and total
// delivery counters, start-to-first-delivery latency, and a key-selected
// seven-segment view of one node's count.
module apo_delivery_monitor_5 #(
    parameter int N_NODES = apo_mon_pkg::N_NODES,
    parameter int CNT_W   = apo_mon_pkg::CNT_W,
    parameter int TOT_W   = apo_mon_pkg::TOT_W,
    parameter int LAT_W   = apo_mon_pkg::LAT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_NODES-1:0] delivered,
    input  logic               start,
    input  logic               sw_clear,
    input  logic               key_next,
    output logic [6:0]         hex_count,
    output logic [6:0]         hex_router,
    output logic [TOT_W-1:0]   total,
    output logic [2:0]         last_router,
    output logic               last_valid,
    output logic [LAT_W-1:0]   latency,
    output logic               lat_valid,
    output logic               lat_timeout
);

    import apo_mon_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;
    localparam logic [LAT_W-1:0] LAT_MAX = '1;

    logic [N_NODES-1:0] d_q;
    logic [N_NODES-1:0] ev;
    logic [CNT_W-1:0]   cnt_q [N_NODES];
    logic [TOT_W:0]     ev_pop;
    logic [TOT_W:0]     total_sum;
    logic [TOT_W-1:0]   total_next;
    logic [2:0]         ev_low;

    logic               key_s1, key_s2, key_s3;
    logic [SEL_W-1:0]   sel_q;
    logic [3:0]         count_digit;

    lat_state_e         state_q, state_d;
    logic [LAT_W-1:0]   lat_cnt;
    logic               lat_restart, lat_count, lat_hit, lat_expire;

    // Delivery strobe history; keeps tracking through sw_clear
    always_ff @(posedge clk) begin
        if (rst) d_q <= '0;
        else     d_q <= delivered;
    end

    // Rising-edge events, their count and the lowest delivering index
    always_comb begin
        ev     = delivered & ~d_q;
        ev_pop = '0;
        ev_low = '0;
        for (int unsigned i = 0; i < N_NODES; i++) begin
            ev_pop = ev_pop + {{TOT_W{1'b0}}, ev[i]};
        end
        for (int unsigned i = N_NODES; i > 0; i--) begin
            if (ev[i-1]) ev_low = 3'(i - 1);
        end
        total_sum  = {1'b0, total} + ev_pop;
        total_next = (total_sum > {1'b0, TOT_MAX}) ? TOT_MAX : total_sum[TOT_W-1:0];
    end

    // Saturating per-node counters, total and last-delivery tracking
    always_ff @(posedge clk) begin
        if (rst || sw_clear) begin
            for (int unsigned i = 0; i < N_NODES; i++) cnt_q[i] <= '0;
            total       <= '0;
            last_router <= '0;
            last_valid  <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < N_NODES; i++) begin
                if (ev[i] && cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
            end
            total <= total_next;
            if (|ev) begin
                last_router <= ev_low;
                last_valid  <= 1'b1;
            end
        end
    end

    // Key synchronizer, falling-edge detect and wrapping node select
    always_ff @(posedge clk) begin
        if (rst) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
            key_s3 <= 1'b1;
            sel_q  <= '0;
        end else begin
            key_s1 <= key_next;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
            if (key_s3 && !key_s2) begin
                sel_q <= (sel_q == SEL_W'(N_NODES - 1)) ? '0 : sel_q + SEL_W'(1);
            end
        end
    end

    // Latency FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Latency FSM next state; start outranks a same-cycle delivery
    always_comb begin
        state_d = state_q;
        if (sw_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start) state_d = RUN;
                RUN: begin
                    if (start)                 state_d = RUN;
                    else if (|ev)              state_d = DONE;
                    else if (lat_cnt == LAT_MAX) state_d = DONE;
                end
                DONE:    if (start) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    // Latency FSM datapath controls
    always_comb begin
        lat_restart = 1'b0;
        lat_count   = 1'b0;
        lat_hit     = 1'b0;
        lat_expire  = 1'b0;
        if (!sw_clear) begin
            case (state_q)
                IDLE, DONE: lat_restart = start;
                RUN: begin
                    if (start)                   lat_restart = 1'b1;
                    else if (|ev)                lat_hit     = 1'b1;
                    else if (lat_cnt == LAT_MAX) lat_expire  = 1'b1;
                    else                         lat_count   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Latency counter and captured measurement
    always_ff @(posedge clk) begin
        if (rst || sw_clear) begin
            lat_cnt     <= '0;
            latency     <= '0;
            lat_valid   <= 1'b0;
            lat_timeout <= 1'b0;
        end else begin
            if (lat_restart) begin
                lat_cnt     <= '0;
                lat_valid   <= 1'b0;
                lat_timeout <= 1'b0;
            end
            if (lat_count) lat_cnt <= lat_cnt + LAT_W'(1);
            if (lat_hit) begin
                latency     <= lat_cnt;
                lat_valid   <= 1'b1;
                lat_timeout <= 1'b0;
            end
            if (lat_expire) begin
                latency     <= LAT_MAX;
                lat_valid   <= 1'b1;
                lat_timeout <= 1'b1;
            end
        end
    end

    // Selected node's count as a display digit
    always_comb begin
        count_digit = 4'(cnt_q[sel_q]);
    end

    hex_to_seg7 u_seg_count (
        .hex (count_digit),
        .seg (hex_count)
    );

    hex_to_seg7 u_seg_router (
        .hex ({1'b0, sel_q}),
        .seg (hex_router)
    );

endmodule

// File: tb/tb_apo_delivery_monitor_5.sv
// Self-checking bench for apo_delivery_monitor_5: directed scenarios plus
// randomized stimulus, every cycle compared against an edge-stamp model.
module tb_apo_delivery_monitor_5;

    logic       clk = 1'b0;
    logic       rst, start, sw_clear, key_next;
    logic [4:0] delivered;
    logic [6:0] hex_count, hex_router;
    logic [7:0] total, latency;
    logic [2:0] last_router;
    logic       last_valid, lat_valid, lat_timeout;

    int checks   = 0;
    int failures = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model state
    int         m_cnt [5];
    int         m_total, m_last, m_lat, m_sel, edge_n, s_edge;
    bit         m_lvalid, m_lv, m_to, measuring;
    logic [4:0] prev_del;
    bit         kh1, kh2, kh3;

    apo_delivery_monitor_5 #(
        .N_NODES (5),
        .CNT_W   (4),
        .TOT_W   (8),
        .LAT_W   (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .delivered   (delivered),
        .start       (start),
        .sw_clear    (sw_clear),
        .key_next    (key_next),
        .hex_count   (hex_count),
        .hex_router  (hex_router),
        .total       (total),
        .last_router (last_router),
        .last_valid  (last_valid),
        .latency     (latency),
        .lat_valid   (lat_valid),
        .lat_timeout (lat_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
        m_total = 0; m_last = 0; m_lvalid = 0;
        m_lat = 0; m_lv = 0; m_to = 0; measuring = 0;
    endtask

    // Apply the rules of one rising edge to the model, using sampled inputs
    task automatic model_edge();
        logic [4:0] ev;
        bit         found;
        edge_n++;
        if (rst) begin
            clear_stats();
            prev_del = '0;
            m_sel = 0;
            kh1 = 1; kh2 = 1; kh3 = 1;
            return;
        end
        // key level seen three edges ago high, two edges ago low -> one press
        if (kh3 && !kh2) m_sel = (m_sel + 1) % 5;
        kh3 = kh2; kh2 = kh1; kh1 = key_next;
        ev = delivered & ~prev_del;
        prev_del = delivered;
        if (sw_clear) begin
            clear_stats();
            return;
        end
        for (int i = 0; i < 5; i++) if (ev[i] && m_cnt[i] < 15) m_cnt[i]++;
        m_total = (m_total + $countones(ev) > 255) ? 255 : m_total + $countones(ev);
        found = 0;
        for (int i = 0; i < 5; i++) begin
            if (ev[i] && !found) begin
                m_last = i; found = 1;
            end
        end
        if (found) m_lvalid = 1;
        if (measuring) begin
            if (start) s_edge = edge_n;
            else if (ev != 0) begin
                m_lat = edge_n - s_edge - 1; m_lv = 1; m_to = 0; measuring = 0;
            end else if (edge_n - s_edge - 1 == 255) begin
                m_lat = 255; m_lv = 1; m_to = 1; measuring = 0;
            end
        end else if (start) begin
            measuring = 1; s_edge = edge_n; m_lv = 0; m_to = 0;
        end
    endtask

    task automatic compare_all();
        chk("total",       total,       m_total);
        chk("last_router", last_router, m_last);
        chk("last_valid",  last_valid,  m_lvalid);
        chk("latency",     latency,     m_lat);
        chk("lat_valid",   lat_valid,   m_lv);
        chk("lat_timeout", lat_timeout, m_to);
        chk("hex_router",  hex_router,  seg_tab[m_sel]);
        chk("hex_count",   hex_count,   seg_tab[m_cnt[m_sel]]);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1; delivered = '0; start = 0; sw_clear = 0; key_next = 1;
        edge_n = 0; s_edge = 0; prev_del = '0; m_sel = 0;
        kh1 = 1; kh2 = 1; kh3 = 1;
        clear_stats();

        step(); step();
        chk("rst_hex_router", hex_router, 7'h40);
        chk("rst_hex_count",  hex_count,  7'h40);
        chk("rst_total",      total,      0);
        chk("rst_lat_valid",  lat_valid,  0);
        rst = 0; step();

        // held level on node 2 counts once
        delivered = 5'b00100; repeat (3) step(); delivered = '0; step();
        chk("n2_total", total, 1);
        chk("n2_last", last_router, 2);
        chk("n2_last_valid", last_valid, 1);

        // three simultaneous rising strobes
        sw_clear = 1; step(); sw_clear = 0; step();
        delivered = 5'b10101; step();
        chk("multi_total", total, 3);
        chk("multi_last", last_router, 0);
        delivered = '0; step();

        // per-node saturation, then view node 1
        sw_clear = 1; step(); sw_clear = 0;
        repeat (20) begin
            delivered = 5'b00010; step(); delivered = '0; step();
        end
        chk("sat_total", total, 20);
        key_next = 0; repeat (3) step(); key_next = 1; step();
        chk("sat_hex_router", hex_router, 7'h79);
        chk("sat_hex_count",  hex_count,  7'h0E);

        // latency: delivery rises seven edges after start
        sw_clear = 1; step(); sw_clear = 0; step();
        start = 1; step(); start = 0;
        repeat (6) step();
        delivered = 5'b10000; step();
        chk("lat_value", latency, 6);
        chk("lat_valid", lat_valid, 1);
        chk("lat_no_timeout", lat_timeout, 0);

        // timeout with no delivery
        delivered = '0; start = 1; step(); start = 0;
        repeat (300) step();
        chk("to_latency", latency, 255);
        chk("to_flag", lat_timeout, 1);
        chk("to_valid", lat_valid, 1);

        // clear beats a same-cycle delivery edge; held level not recounted
        sw_clear = 1; delivered = 5'b01011; step();
        chk("clr_total", total, 0);
        chk("clr_last_valid", last_valid, 0);
        chk("clr_latency", latency, 0);
        chk("clr_lat_valid", lat_valid, 0);
        sw_clear = 0; step();
        chk("clr_held_total", total, 0);
        delivered = '0; step();

        // five presses walk the select 1,2,3,4,0
        rst = 1; step(); rst = 0; step();
        for (int p = 1; p <= 5; p++) begin
            key_next = 0; repeat (3) step();
            chk("sel_walk", hex_router, seg_tab[p % 5]);
            key_next = 1; repeat (2) step();
        end

        // reset in the middle of a measurement returns to idle
        start = 1; step(); start = 0;
        repeat (5) step();
        rst = 1; step(); rst = 0;
        chk("rst_run_valid", lat_valid, 0);
        delivered = 5'b00001; step();
        chk("rst_run_idle", lat_valid, 0);
        delivered = '0; step();

        // randomized traffic, clears only in the second half
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 99) < 25) delivered[i] = ~delivered[i];
            end
            start    = ($urandom_range(0, 99) < 4);
            sw_clear = (c >= 2000) && ($urandom_range(0, 299) == 0);
            rst      = ($urandom_range(0, 1499) == 0);
            if ($urandom_range(0, 99) < 8) key_next = ~key_next;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
